mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one memory
// channel. Only one transaction is in flight. Data has priority, but a fetch
// cannot be starved for more than MAX_D_STREAK data grants.
module mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk_100mhz,
  input  logic        rst_n_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_gnt_out,
  output logic        if_rvalid_out,
  output logic [31:0] if_rdata_out,
  input  logic        d_req_in,
  input  logic        d_we_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  output logic        d_gnt_out,
  output logic        d_rvalid_out,
  output logic [31:0] d_rdata_out,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  input  logic        mem_ready_in,
  input  logic        mem_rvalid_in,
  input  logic [31:0] mem_rdata_in
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [3:0] MaxStreak = 4'(MAX_D_STREAK);

  state_t      state_q, state_d;
  logic        own_d_q, own_d_d;   // 1: data port owns the transaction
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  streak_q, streak_d;
  logic        if_gnt_q, if_gnt_d;
  logic        d_gnt_q, d_gnt_d;
  logic        if_rv_q, if_rv_d;
  logic        d_rv_q, d_rv_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        fetch_win;

  assign fetch_win = if_req_in && (!d_req_in || (streak_q == MaxStreak));

  always_comb begin
    state_d    = state_q;
    own_d_d    = own_d_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    streak_d   = streak_q;
    if_gnt_d   = 1'b0;
    d_gnt_d    = 1'b0;
    if_rv_d    = 1'b0;
    d_rv_d     = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (fetch_win) begin
          state_d  = ISSUE;
          own_d_d  = 1'b0;
          we_d     = 1'b0;
          addr_d   = if_addr_in;
          wdata_d  = '0;
          streak_d = '0;
          if_gnt_d = 1'b1;
        end else if (d_req_in) begin
          state_d  = ISSUE;
          own_d_d  = 1'b1;
          we_d     = d_we_in;
          addr_d   = d_addr_in;
          wdata_d  = d_wdata_in;
          d_gnt_d  = 1'b1;
          // Only grants that make a fetch wait count toward starvation.
          if (if_req_in && streak_q != 4'hF) streak_d = streak_q + 4'd1;
        end
      end
      ISSUE: begin
        if (mem_ready_in) begin
          if (we_q) begin
            state_d   = IDLE;
            d_rv_d    = 1'b1;
            d_rdata_d = '0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid_in) begin
          state_d = IDLE;
          if (own_d_q) begin
            d_rv_d    = 1'b1;
            d_rdata_d = mem_rdata_in;
          end else begin
            if_rv_d    = 1'b1;
            if_rdata_d = mem_rdata_in;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      own_d_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      streak_q   <= '0;
      if_gnt_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      if_rv_q    <= 1'b0;
      d_rv_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      own_d_q    <= own_d_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      streak_q   <= streak_d;
      if_gnt_q   <= if_gnt_d;
      d_gnt_q    <= d_gnt_d;
      if_rv_q    <= if_rv_d;
      d_rv_q     <= d_rv_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Channel fields are only meaningful while a request is presented.
  assign mem_req_out   = (state_q == ISSUE);
  assign mem_we_out    = mem_req_out & we_q;
  assign mem_addr_out  = mem_req_out ? addr_q  : '0;
  assign mem_wdata_out = mem_req_out ? wdata_q : '0;

  assign if_gnt_out    = if_gnt_q;
  assign d_gnt_out     = d_gnt_q;
  assign if_rvalid_out = if_rv_q;
  assign d_rvalid_out  = d_rv_q;
  assign if_rdata_out  = if_rdata_q;
  assign d_rdata_out   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, store, collision, starvation,
// reset during WAIT and stray responses.
module tb_mem_arbiter;

  logic        clk_100mhz = 1'b0;
  logic        rst_n_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_gnt_out, if_rvalid_out;
  logic [31:0] if_rdata_out;
  logic        d_req_in, d_we_in;
  logic [31:0] d_addr_in, d_wdata_in;
  logic        d_gnt_out, d_rvalid_out;
  logic [31:0] d_rdata_out;
  logic        mem_req_out, mem_we_out;
  logic [31:0] mem_addr_out, mem_wdata_out;
  logic        mem_ready_in, mem_rvalid_in;
  logic [31:0] mem_rdata_in;

  int errors = 0;
  int checks = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  mem_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk_100mhz(clk_100mhz), .rst_n_in(rst_n_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .if_gnt_out(if_gnt_out), .if_rvalid_out(if_rvalid_out), .if_rdata_out(if_rdata_out),
    .d_req_in(d_req_in), .d_we_in(d_we_in), .d_addr_in(d_addr_in), .d_wdata_in(d_wdata_in),
    .d_gnt_out(d_gnt_out), .d_rvalid_out(d_rvalid_out), .d_rdata_out(d_rdata_out),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
    .mem_ready_in(mem_ready_in), .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in)
  );

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; if_req_in = 0; if_addr_in = 0; d_req_in = 0; d_we_in = 0;
    d_addr_in = 0; d_wdata_in = 0; mem_ready_in = 0; mem_rvalid_in = 0; mem_rdata_in = 0;
    tick(); tick();
    checks++; if ({if_gnt_out, d_gnt_out, if_rvalid_out, d_rvalid_out, mem_req_out, mem_we_out} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 000000", {if_gnt_out, d_gnt_out, if_rvalid_out, d_rvalid_out, mem_req_out, mem_we_out}); end
    checks++; if ({mem_addr_out, mem_wdata_out, if_rdata_out, d_rdata_out} !== 128'b0) begin errors++; $display("FAIL reset_data: got %h want 0", {mem_addr_out, mem_wdata_out, if_rdata_out, d_rdata_out}); end
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    int rv_cnt = 0;
    if_req_in = 1; if_addr_in = 32'h10;
    tick();
    checks++; if ({if_gnt_out, d_gnt_out, mem_req_out, mem_we_out} !== 4'b1010) begin errors++; $display("FAIL fetch_gnt: got %b want 1010", {if_gnt_out, d_gnt_out, mem_req_out, mem_we_out}); end
    checks++; if (mem_addr_out !== 32'h10 || mem_wdata_out !== 32'h0) begin errors++; $display("FAIL fetch_fields: got addr %h wdata %h want 10/0", mem_addr_out, mem_wdata_out); end
    if_req_in = 0; mem_ready_in = 1;
    tick();
    checks++; if ({if_gnt_out, mem_req_out, if_rvalid_out} !== 3'b000) begin errors++; $display("FAIL fetch_wait: got %b want 000", {if_gnt_out, mem_req_out, if_rvalid_out}); end
    mem_ready_in = 0; mem_rvalid_in = 1; mem_rdata_in = 32'h00B58593;
    tick();
    mem_rvalid_in = 0;
    checks++; if (if_rvalid_out !== 1'b1 || if_rdata_out !== 32'h00B58593 || d_rvalid_out !== 1'b0) begin errors++; $display("FAIL fetch_resp: got rv %b data %h drv %b want 1/00b58593/0", if_rvalid_out, if_rdata_out, d_rvalid_out); end
    for (int i = 0; i < 4; i++) begin
      if (if_rvalid_out) rv_cnt++;
      tick();
    end
    checks++; if (rv_cnt !== 1) begin errors++; $display("FAIL fetch_once: got %0d rvalid pulses want 1", rv_cnt); end
    checks++; if (if_rdata_out !== 32'h00B58593) begin errors++; $display("FAIL fetch_hold: got %h want 00b58593", if_rdata_out); end
  endtask

  task automatic test_store();
    d_req_in = 1; d_we_in = 1; d_addr_in = 32'h100; d_wdata_in = 32'hDEADBEEF;
    tick();
    checks++; if ({d_gnt_out, if_gnt_out} !== 2'b10) begin errors++; $display("FAIL store_gnt: got %b want 10", {d_gnt_out, if_gnt_out}); end
    d_req_in = 0; d_we_in = 0; d_addr_in = 32'h0; d_wdata_in = 32'h0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({mem_req_out, mem_we_out} !== 2'b11 || mem_addr_out !== 32'h100 || mem_wdata_out !== 32'hDEADBEEF) begin errors++; $display("FAIL store_hold%0d: got req/we %b addr %h wdata %h want 11/100/deadbeef", i, {mem_req_out, mem_we_out}, mem_addr_out, mem_wdata_out); end
      tick();
    end
    checks++; if (mem_req_out !== 1'b1 || d_gnt_out !== 1'b0 || d_rvalid_out !== 1'b0) begin errors++; $display("FAIL store_issue: got req %b gnt %b rv %b want 1/0/0", mem_req_out, d_gnt_out, d_rvalid_out); end
    mem_ready_in = 1;
    tick();
    mem_ready_in = 0;
    checks++; if (d_rvalid_out !== 1'b1 || d_rdata_out !== 32'h0 || mem_req_out !== 1'b0) begin errors++; $display("FAIL store_done: got rv %b data %h req %b want 1/0/0", d_rvalid_out, d_rdata_out, mem_req_out); end
    tick();
    checks++; if (d_rvalid_out !== 1'b0 || if_rvalid_out !== 1'b0) begin errors++; $display("FAIL store_pulse: got drv %b irv %b want 0/0", d_rvalid_out, if_rvalid_out); end
  endtask

  task automatic test_collision();
    if_req_in = 1; if_addr_in = 32'h20; d_req_in = 1; d_we_in = 0; d_addr_in = 32'h200;
    tick();
    checks++; if ({d_gnt_out, if_gnt_out} !== 2'b10 || mem_addr_out !== 32'h200) begin errors++; $display("FAIL coll_first: got gnt %b addr %h want 10/200", {d_gnt_out, if_gnt_out}, mem_addr_out); end
    d_req_in = 0; mem_ready_in = 1;
    tick();
    mem_ready_in = 0; mem_rvalid_in = 1; mem_rdata_in = 32'h11111111;
    tick();
    mem_rvalid_in = 0;
    checks++; if (d_rvalid_out !== 1'b1 || d_rdata_out !== 32'h11111111 || if_rvalid_out !== 1'b0) begin errors++; $display("FAIL coll_dresp: got drv %b data %h irv %b want 1/11111111/0", d_rvalid_out, d_rdata_out, if_rvalid_out); end
    tick();
    checks++; if ({d_gnt_out, if_gnt_out} !== 2'b01 || mem_addr_out !== 32'h20) begin errors++; $display("FAIL coll_second: got gnt %b addr %h want 01/20", {d_gnt_out, if_gnt_out}, mem_addr_out); end
    if_req_in = 0; mem_ready_in = 1;
    tick();
    mem_ready_in = 0; mem_rvalid_in = 1; mem_rdata_in = 32'h22222222;
    tick();
    mem_rvalid_in = 0;
    checks++; if (if_rvalid_out !== 1'b1 || if_rdata_out !== 32'h22222222 || d_rvalid_out !== 1'b0 || d_rdata_out !== 32'h11111111) begin errors++; $display("FAIL coll_iresp: got irv %b idata %h drv %b ddata %h want 1/22222222/0/11111111", if_rvalid_out, if_rdata_out, d_rvalid_out, d_rdata_out); end
    tick();
  endtask

  task automatic test_starvation();
    logic [9:0] exp_fetch = 10'b1000010000;  // bit k: grant k is a fetch
    logic [9:0] got_fetch = '0;
    int n = 0;
    if_req_in = 1; if_addr_in = 32'h30; d_req_in = 1; d_we_in = 0; d_addr_in = 32'h300;
    mem_ready_in = 1; mem_rvalid_in = 1; mem_rdata_in = 32'h55555555;
    for (int c = 0; c < 100 && n < 10; c++) begin
      tick();
      if (if_gnt_out || d_gnt_out) begin
        got_fetch[n] = if_gnt_out & ~d_gnt_out;
        n++;
        if (n == 10) begin if_req_in = 0; d_req_in = 0; end
      end
    end
    checks++; if (n !== 10) begin errors++; $display("FAIL starve_timeout: got %0d grants want 10", n); end
    for (int k = 0; k < 10; k++) begin
      checks++; if (got_fetch[k] !== exp_fetch[k]) begin errors++; $display("FAIL starve_grant%0d: got %s want %s", k, got_fetch[k] ? "I" : "D", exp_fetch[k] ? "I" : "D"); end
    end
    tick(); tick(); tick();
    mem_ready_in = 0; mem_rvalid_in = 0;
    tick();
    checks++; if (if_rdata_out !== 32'h55555555 || mem_req_out !== 1'b0) begin errors++; $display("FAIL starve_drain: got idata %h req %b want 55555555/0", if_rdata_out, mem_req_out); end
  endtask

  task automatic test_reset_in_wait();
    d_req_in = 1; d_we_in = 0; d_addr_in = 32'h300;
    tick();
    d_req_in = 0; mem_ready_in = 1;
    tick();
    mem_ready_in = 0;
    rst_n_in = 0;
    #1;
    checks++; if (if_rdata_out !== 32'h0 || d_rdata_out !== 32'h0 || mem_req_out !== 1'b0) begin errors++; $display("FAIL rst_async: got idata %h ddata %h req %b want 0/0/0", if_rdata_out, d_rdata_out, mem_req_out); end
    tick();
    rst_n_in = 1; mem_rvalid_in = 1; mem_rdata_in = 32'h33333333;
    tick();
    mem_rvalid_in = 0;
    checks++; if ({d_rvalid_out, if_rvalid_out, mem_req_out, d_gnt_out, if_gnt_out} !== 5'b0 || d_rdata_out !== 32'h0) begin errors++; $display("FAIL rst_stray: got ctrl %b ddata %h want 00000/0", {d_rvalid_out, if_rvalid_out, mem_req_out, d_gnt_out, if_gnt_out}, d_rdata_out); end
    tick();
    checks++; if (d_rvalid_out !== 1'b0 || if_rvalid_out !== 1'b0) begin errors++; $display("FAIL rst_quiet: got drv %b irv %b want 0/0", d_rvalid_out, if_rvalid_out); end
    if_req_in = 1; if_addr_in = 32'h40;
    tick();
    checks++; if (if_gnt_out !== 1'b1 || mem_addr_out !== 32'h40) begin errors++; $display("FAIL rst_idle: got gnt %b addr %h want 1/40", if_gnt_out, mem_addr_out); end
    if_req_in = 0; mem_ready_in = 1;
    tick();
    mem_ready_in = 0; mem_rvalid_in = 1; mem_rdata_in = 32'h44444444;
    tick();
    mem_rvalid_in = 0;
    checks++; if (if_rvalid_out !== 1'b1 || if_rdata_out !== 32'h44444444) begin errors++; $display("FAIL rst_after: got rv %b data %h want 1/44444444", if_rvalid_out, if_rdata_out); end
    tick();
  endtask

  task automatic test_stray_response();
    mem_rvalid_in = 1; mem_rdata_in = 32'hFFFFFFFF; mem_ready_in = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({if_gnt_out, d_gnt_out, if_rvalid_out, d_rvalid_out, mem_req_out} !== 5'b0 || if_rdata_out !== 32'h44444444 || d_rdata_out !== 32'h0) begin errors++; $display("FAIL stray%0d: got ctrl %b idata %h ddata %h want 00000/44444444/0", i, {if_gnt_out, d_gnt_out, if_rvalid_out, d_rvalid_out, mem_req_out}, if_rdata_out, d_rdata_out); end
    end
    mem_rvalid_in = 0; mem_ready_in = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_collision();
    test_starvation();
    test_reset_in_wait();
    test_stray_response();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
